// File: rtl/ysyx_22040127_fetch.sv
// Instruction fetch: owns the PC, issues one imem read at a time, and hands {ebreak, inst, pc} to decode.
// Latency: the response is presented to decode in the same cycle it returns from memory (not registered).
// Backpressure: while decode stalls, the word is parked in a hold buffer; redirects cancel in-flight or held words.
module ysyx_22040127_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_allowin,
    input  logic        id_branch_taken,
    input  logic [31:0] id_branch_result,
    input  logic        csr_redirect_valid,
    input  logic [31:0] csr_redirect_pc,
    output logic        if_to_id_valid,
    output logic [64:0] if_to_id_bus,
    output logic [31:0] if_instruction_reg,
    output logic        if_instruction_blocked,
    output logic        if_flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_reg_q, inst_reg_d;
    logic        flush_q, flush_d;

    logic        br_redirect;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] deliver_inst;

    // CSR redirect outranks a branch; a branch only redirects when it leaves decode this cycle
    always_comb begin
        br_redirect = id_branch_taken && id_allowin;
        redirect    = csr_redirect_valid || br_redirect;
        redirect_pc = csr_redirect_valid ? csr_redirect_pc : id_branch_result;
    end

    // Next-state, PC and hold-buffer update
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_reg_d = inst_reg_q;
        flush_d    = csr_redirect_valid;
        unique case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    // An accepted request still owes us a response that must be swallowed
                    state_d = imem_req_ready ? S_DROP : S_REQ;
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (redirect) begin
                        pc_d    = redirect_pc;
                        state_d = S_REQ;
                    end else if (id_allowin) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_REQ;
                    end else begin
                        inst_reg_d = imem_resp_data;
                        state_d    = S_HOLD;
                    end
                end else if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (id_allowin) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // State registers with synchronous reset; a late response after reset lands in REQ and is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            inst_reg_q <= 32'd0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_reg_q <= inst_reg_d;
            flush_q    <= flush_d;
        end
    end

    // Output decode; everything is forced low while reset is held
    always_comb begin
        deliver_inst           = (state_q == S_HOLD) ? inst_reg_q : imem_resp_data;
        imem_req_valid         = 1'b0;
        imem_addr              = 32'd0;
        if_to_id_valid         = 1'b0;
        if_to_id_bus           = 65'd0;
        if_instruction_reg     = 32'd0;
        if_instruction_blocked = 1'b0;
        if_flush               = 1'b0;
        if (!rst) begin
            imem_req_valid         = (state_q == S_REQ);
            imem_addr              = pc_q;
            if_to_id_valid         = !csr_redirect_valid &&
                                     (((state_q == S_WAIT) && imem_resp_valid) ||
                                      (state_q == S_HOLD));
            if_to_id_bus           = {(deliver_inst == EBREAK_INST), deliver_inst, pc_q};
            if_instruction_reg     = inst_reg_q;
            if_instruction_blocked = (state_q == S_HOLD);
            if_flush               = flush_q;
        end
    end

endmodule
